bypass_scoreboard: RTL

Parametrised operand-bypass and hazard unit for the in-order integer pipeline; successor to the fixed two-stage, five-operand forwarding mux. Resolves every source operand of the issuing instruction against N forwarding stages with youngest-first priority. Tracks outstanding long-latency writes (loads, mul/div) in a per-register scoreboard and raises a stall when an operand is not yet producible. Sits between the register-file read in ID and the EX operand latches.

---
 rtl/cpuDefine_pkg.sv | 19 +
 rtl/bypass_port_mux.sv | 48 ++++
 rtl/bypass_scoreboard.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpuDefine_pkg.sv
// Shared CPU types for the bypass/hazard unit: register number, data word,
// default register count and the per-stage forwarding source record.
package cpuDefine;

    localparam int unsigned GR_W     = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NREG_DEF = 32;

    typedef logic [GR_W-1:0]   Gr;
    typedef logic [DATA_W-1:0] DType;

    typedef struct packed {
        logic wen;
        Gr    rd_no;
        DType data;
        logic data_vld;
    } fwd_src_t;

endpackage

// File: rtl/bypass_port_mux.sv
// Single source-operand resolver: youngest-first forwarding select over all
// forwarding stages, register-0 zeroing, and the operand's hazard flag.
module bypass_port_mux
    import cpuDefine::*;
#(
    parameter int unsigned NUM_FWD_STAGES = 3
) (
    input  logic                                used,
    input  logic [GR_W-1:0]                     rs_no,
    input  logic [DATA_W-1:0]                   rf_data,
    input  fwd_src_t [NUM_FWD_STAGES-1:0]       fwd,
    input  logic                                pending,
    input  logic                                cmpl_hit,
    output logic [DATA_W-1:0]                   data,
    output logic                                hazard
);

    logic hit;
    logic hit_vld;

    // Pick the youngest matching stage, fall back to the register file, then flag a hazard
    always_comb begin
        hit     = 1'b0;
        hit_vld = 1'b1;
        data    = rf_data;
        for (int unsigned s = 0; s < NUM_FWD_STAGES; s++) begin
            if (!hit && fwd[s].wen && (fwd[s].rd_no == rs_no)) begin
                hit     = 1'b1;
                hit_vld = fwd[s].data_vld;
                data    = fwd[s].data;
            end
        end
        if (rs_no == '0) begin
            data = '0;
        end

        hazard = 1'b0;
        if (used && (rs_no != '0)) begin
            // A stage match hides the scoreboard: only its result availability matters.
            if (hit) begin
                hazard = !hit_vld;
            end else begin
                hazard = pending && !cmpl_hit;
            end
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// Operand bypass and hazard unit: resolves NUM_RD_PORTS source operands against
// NUM_FWD_STAGES forwarding stages and tracks outstanding long-latency writes.
// Optional feature macro: BYPASS_PERF_CNT_EN adds saturating stall-cycle and
// forwarding-hit performance counters.
module bypass_scoreboard
    import cpuDefine::*;
#(
    parameter int unsigned NUM_RD_PORTS   = 3,
    parameter int unsigned NUM_FWD_STAGES = 3,
    parameter int unsigned NREG           = NREG_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_RD_PORTS-1:0]                 rs_used,
    input  logic [NUM_RD_PORTS-1:0][GR_W-1:0]       rs_no,
    input  logic [NUM_RD_PORTS-1:0][DATA_W-1:0]     rs_rf_data,
    input  logic [NUM_FWD_STAGES-1:0]               fwd_wen,
    input  logic [NUM_FWD_STAGES-1:0][GR_W-1:0]     fwd_rd_no,
    input  logic [NUM_FWD_STAGES-1:0][DATA_W-1:0]   fwd_data,
    input  logic [NUM_FWD_STAGES-1:0]               fwd_data_vld,
    input  logic                                    issue_valid,
    input  logic                                    issue_long,
    input  logic [GR_W-1:0]                         issue_rd_no,
    input  logic                                    cmpl_valid,
    input  logic [GR_W-1:0]                         cmpl_rd_no,
    input  logic                                    flush,
    output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]     rs_data_o,
    output logic                                    stall_o
`ifdef BYPASS_PERF_CNT_EN
   ,output logic [31:0]                             perf_stall_cyc,
    output logic [31:0]                             perf_fwd_hit
`endif
);

    fwd_src_t [NUM_FWD_STAGES-1:0] fwd_src;
    logic [NREG-1:0]               pending;
    logic [NREG-1:0]               pending_nxt;
    logic [NUM_RD_PORTS-1:0]       hazard;
    logic                          issue_fire;

    // Gather the per-stage forwarding inputs into source records
    always_comb begin
        for (int unsigned s = 0; s < NUM_FWD_STAGES; s++) begin
            fwd_src[s] = '{wen:      fwd_wen[s],
                           rd_no:    fwd_rd_no[s],
                           data:     fwd_data[s],
                           data_vld: fwd_data_vld[s]};
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_RD_PORTS; p++) begin : g_port
            bypass_port_mux #(
                .NUM_FWD_STAGES (NUM_FWD_STAGES)
            ) u_mux (
                .used     (rs_used[p]),
                .rs_no    (rs_no[p]),
                .rf_data  (rs_rf_data[p]),
                .fwd      (fwd_src),
                .pending  (pending[rs_no[p]]),
                .cmpl_hit (cmpl_valid && (cmpl_rd_no == rs_no[p])),
                .data     (rs_data_o[p]),
                .hazard   (hazard[p])
            );
        end
    endgenerate

    assign stall_o    = |hazard;
    assign issue_fire = issue_valid && !stall_o && !flush;

    // Next scoreboard state: clear on completion first so a same-register issue wins
    always_comb begin
        pending_nxt = pending;
        if (cmpl_valid) begin
            pending_nxt[cmpl_rd_no] = 1'b0;
        end
        if (issue_fire && issue_long && (issue_rd_no != '0)) begin
            pending_nxt[issue_rd_no] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register; flush drops every in-flight long op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

`ifdef BYPASS_PERF_CNT_EN
    logic any_fwd_hit;

    // A used, non-zero operand that matches any writing stage takes forwarded data
    always_comb begin
        any_fwd_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RD_PORTS; i++) begin
            for (int unsigned s = 0; s < NUM_FWD_STAGES; s++) begin
                if (rs_used[i] && (rs_no[i] != '0) && fwd_wen[s] &&
                    (fwd_rd_no[s] == rs_no[i])) begin
                    any_fwd_hit = 1'b1;
                end
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_fwd_hit   <= '0;
        end else begin
            if (stall_o && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (any_fwd_hit && (perf_fwd_hit != '1)) begin
                perf_fwd_hit <= perf_fwd_hit + 32'd1;
            end
        end
    end
`endif

endmodule
